pz_config_sequencer: RTL

//  Frame-synchronous configuration controller for the pole/zero pixel datapath. Software writes

---
 rtl/pz_config_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pz_config_sequencer.sv
// pz_config_sequencer
//   Frame-synchronous configuration controller for the pole/zero pixel datapath.
//   Software writes pole/zero words and masks into a shadow bank. A commit write
//   arms the block. The shadow bank is then copied to the active bank on the next
//   start-of-frame handshake, so a frame never sees a mix of two configurations.
//
// Ports
//   out_stream_aclk : clock (the only clock)
//   periph_resetn   : asynchronous active-low reset
//   cfg_wr_en/sel/data : shadow write port
//     sel 0..NUM_PZ-1 = pz word {re,im}; NUM_PZ = zero mask; NUM_PZ+1 = enable mask;
//     NUM_PZ+2 = commit (data bit0); anything higher is unmapped
//   coord_valid/ready/sof : coordinate handshake; a sof handshake marks a frame start
//   act_pz_flat, act_zero_mask, act_en_mask : active bank (slot i at [32*i +: 32])
//   no_z / no_p     : enabled zero / pole counts of the active bank
//   commit_pending  : a commit is armed and waiting for sof
//   commit_done     : one-cycle pulse after the active bank updated
//   cfg_wr_err      : one-cycle pulse after a write to an unmapped sel
//   frame_count     : number of sof handshakes, wrapping at 16 bits
module pz_config_sequencer #(
  parameter int NUM_PZ    = 8,
  parameter int SEL_WIDTH = 4,
  parameter int CNT_WIDTH = 4
) (
  input  logic                    out_stream_aclk,
  input  logic                    periph_resetn,
  input  logic                    cfg_wr_en,
  input  logic [SEL_WIDTH-1:0]    cfg_wr_sel,
  input  logic [31:0]             cfg_wr_data,
  input  logic                    coord_valid,
  input  logic                    coord_ready,
  input  logic                    coord_sof,
  output logic [32*NUM_PZ-1:0]    act_pz_flat,
  output logic [NUM_PZ-1:0]       act_zero_mask,
  output logic [NUM_PZ-1:0]       act_en_mask,
  output logic [CNT_WIDTH-1:0]    no_z,
  output logic [CNT_WIDTH-1:0]    no_p,
  output logic                    commit_pending,
  output logic                    commit_done,
  output logic                    cfg_wr_err,
  output logic [15:0]             frame_count
);

  localparam logic [SEL_WIDTH-1:0] SEL_ZMASK  = SEL_WIDTH'(NUM_PZ);
  localparam logic [SEL_WIDTH-1:0] SEL_ENMASK = SEL_WIDTH'(NUM_PZ + 1);
  localparam logic [SEL_WIDTH-1:0] SEL_COMMIT = SEL_WIDTH'(NUM_PZ + 2);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [NUM_PZ-1:0] v);
    logic [CNT_WIDTH-1:0] c;
    c = {CNT_WIDTH{1'b0}};
    for (int i = 0; i < NUM_PZ; i++) begin
      c = c + CNT_WIDTH'(v[i]);
    end
    return c;
  endfunction

  state_e                 state_q, state_d;
  logic [32*NUM_PZ-1:0]   shadow_pz_q;
  logic [NUM_PZ-1:0]      shadow_zm_q;
  logic [NUM_PZ-1:0]      shadow_en_q;
  logic [32*NUM_PZ-1:0]   act_pz_q;
  logic [NUM_PZ-1:0]      act_zm_q;
  logic [NUM_PZ-1:0]      act_en_q;
  logic [CNT_WIDTH-1:0]   no_z_q;
  logic [CNT_WIDTH-1:0]   no_p_q;
  logic                   commit_done_q;
  logic                   cfg_wr_err_q;
  logic [15:0]            frame_count_q;

  logic sof_hs_s;
  logic commit_req_s;
  logic commit_s;
  logic wr_zm_s;
  logic wr_en_s;
  logic wr_bad_s;

  // Handshake and write-address decode
  always_comb begin
    sof_hs_s     = coord_valid & coord_ready & coord_sof;
    commit_req_s = cfg_wr_en && (cfg_wr_sel == SEL_COMMIT) && cfg_wr_data[0];
    wr_zm_s      = cfg_wr_en && (cfg_wr_sel == SEL_ZMASK);
    wr_en_s      = cfg_wr_en && (cfg_wr_sel == SEL_ENMASK);
    wr_bad_s     = cfg_wr_en && (cfg_wr_sel > SEL_COMMIT);
  end

  // Commit FSM next-state: a commit write only arms from IDLE, so a write that
  // coincides with sof in IDLE waits for the following frame.
  always_comb begin
    state_d  = state_q;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit_req_s) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (sof_hs_s) begin
          commit_s = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_ARMED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shadow bank: written by software; never visible on the outputs directly
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      shadow_pz_q <= '0;
      shadow_zm_q <= '0;
      shadow_en_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PZ; i++) begin
        if (cfg_wr_en && (cfg_wr_sel == SEL_WIDTH'(i))) begin
          shadow_pz_q[32*i +: 32] <= cfg_wr_data;
        end
      end
      if (wr_zm_s) begin
        shadow_zm_q <= cfg_wr_data[NUM_PZ-1:0];
      end
      if (wr_en_s) begin
        shadow_en_q <= cfg_wr_data[NUM_PZ-1:0];
      end
    end
  end

  // Active bank: copies the pre-edge shadow contents on the commit edge, so a
  // shadow write on that same edge is not part of this commit.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      act_pz_q <= '0;
      act_zm_q <= '0;
      act_en_q <= '0;
      no_z_q   <= '0;
      no_p_q   <= '0;
    end else if (commit_s) begin
      act_pz_q <= shadow_pz_q;
      act_zm_q <= shadow_zm_q;
      act_en_q <= shadow_en_q;
      no_z_q   <= popcount(shadow_en_q & shadow_zm_q);
      no_p_q   <= popcount(shadow_en_q & ~shadow_zm_q);
    end
  end

  // Status pulses and frame counter
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      commit_done_q <= 1'b0;
      cfg_wr_err_q  <= 1'b0;
      frame_count_q <= 16'h0000;
    end else begin
      commit_done_q <= commit_s;
      cfg_wr_err_q  <= wr_bad_s;
      if (sof_hs_s) begin
        frame_count_q <= frame_count_q + 16'h0001;
      end
    end
  end

  assign act_pz_flat    = act_pz_q;
  assign act_zero_mask  = act_zm_q;
  assign act_en_mask    = act_en_q;
  assign no_z           = no_z_q;
  assign no_p           = no_p_q;
  assign commit_pending = (state_q == ST_ARMED);
  assign commit_done    = commit_done_q;
  assign cfg_wr_err     = cfg_wr_err_q;
  assign frame_count    = frame_count_q;

endmodule
